// File: rtl/branch_cond_unit_if.sv
// rtl/branch_cond_unit_if.sv - request/response handshake bundle for branch_cond_unit
interface branch_cond_unit_if #(
    parameter int PC_W  = 9,
    parameter int OFF_W = 8
);
    logic             req_valid;
    logic             req_ready;
    logic [2:0]       cond;
    logic [PC_W-1:0]  pc_in;
    logic [OFF_W-1:0] offset;
    logic             resp_valid;
    logic             resp_ready;
    logic             taken;
    logic             illegal;
    logic [PC_W-1:0]  next_pc;

    modport master (
        output req_valid, cond, pc_in, offset, resp_ready,
        input  req_ready, resp_valid, taken, illegal, next_pc
    );

    modport slave (
        input  req_valid, cond, pc_in, offset, resp_ready,
        output req_ready, resp_valid, taken, illegal, next_pc
    );
endinterface

// File: rtl/branch_cond_unit.sv
// rtl/branch_cond_unit.sv - nvz status register and branch condition/next-PC resolver (optional BRANCH_STATS_EN)
module branch_cond_unit #(
    parameter int PC_W  = 9,
    parameter int OFF_W = 8
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        load_s,
    input  logic [2:0]  nvz_in,
    output logic [2:0]  status,
`ifdef BRANCH_STATS_EN
    output logic [15:0] taken_count,
`endif
    branch_cond_unit_if.slave bus
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EVAL = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t           state;
    logic [2:0]       cond_q;
    logic [PC_W-1:0]  pc_q;
    logic [OFF_W-1:0] off_q;

    logic             eval_taken;
    logic             eval_illegal;
    logic [PC_W-1:0]  pc_inc;
    logic [PC_W-1:0]  off_sext;
    logic [PC_W-1:0]  eval_next_pc;
    logic             flag_n;
    logic             flag_v;
    logic             flag_z;

    assign flag_z = status[0];
    assign flag_v = status[1];
    assign flag_n = status[2];

    // Evaluated against the live status register, so a load at the accept edge is seen.
    always_comb begin
        eval_taken   = 1'b0;
        eval_illegal = 1'b0;
        case (cond_q)
            3'b000:  eval_taken = 1'b1;
            3'b001:  eval_taken = flag_z;
            3'b010:  eval_taken = ~flag_z;
            3'b011:  eval_taken = flag_n ^ flag_v;
            3'b100:  eval_taken = (flag_n ^ flag_v) | flag_z;
            default: eval_illegal = 1'b1;
        endcase
    end

    assign off_sext     = {{(PC_W-OFF_W){off_q[OFF_W-1]}}, off_q};
    assign pc_inc       = pc_q + PC_W'(1);
    assign eval_next_pc = eval_taken ? (pc_inc + off_sext) : pc_inc;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state          <= IDLE;
            status         <= 3'b000;
            cond_q         <= 3'b000;
            pc_q           <= '0;
            off_q          <= '0;
            bus.req_ready  <= 1'b1;
            bus.resp_valid <= 1'b0;
            bus.taken      <= 1'b0;
            bus.illegal    <= 1'b0;
            bus.next_pc    <= '0;
        end else begin
            if (load_s) begin
                status <= nvz_in;
            end
            case (state)
                IDLE: begin
                    if (bus.req_valid) begin
                        cond_q        <= bus.cond;
                        pc_q          <= bus.pc_in;
                        off_q         <= bus.offset;
                        bus.req_ready <= 1'b0;
                        state         <= EVAL;
                    end
                end
                EVAL: begin
                    bus.taken      <= eval_taken;
                    bus.illegal    <= eval_illegal;
                    bus.next_pc    <= eval_next_pc;
                    bus.resp_valid <= 1'b1;
                    state          <= RESP;
                end
                RESP: begin
                    if (bus.resp_ready) begin
                        bus.resp_valid <= 1'b0;
                        bus.req_ready  <= 1'b1;
                        state          <= IDLE;
                    end
                end
                default: begin
                    bus.resp_valid <= 1'b0;
                    bus.req_ready  <= 1'b1;
                    state          <= IDLE;
                end
            endcase
        end
    end

`ifdef BRANCH_STATS_EN
    // illegal responses always carry taken=0, so they never count.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            taken_count <= 16'h0000;
        end else if (state == RESP && bus.resp_ready && bus.taken
                     && taken_count != 16'hFFFF) begin
            taken_count <= taken_count + 16'h0001;
        end
    end
`endif

endmodule
